// File: rtl/wb_port_arbiter.sv
// Shares the register-file/PS write port between the memory return path (always wins)
// and the ALU writeback path, which is parked in an in-order skid FIFO when it loses.
module wb_port_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic                       alu_reg_write,
  input  logic [ADDR_W-1:0]          alu_reg_addr,
  input  logic [DATA_W-1:0]          alu_reg_data,
  input  logic                       alu_ps_write,
  input  logic                       alu_ps_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic                       mem_reg_write,
  input  logic [ADDR_W-1:0]          mem_reg_addr,
  input  logic [DATA_W-1:0]          mem_reg_data,
  input  logic                       mem_ps_write,
  input  logic                       mem_ps_data,
  output logic                       wb_reg_write,
  output logic [ADDR_W-1:0]          wb_reg_addr,
  output logic [DATA_W-1:0]          wb_reg_data,
  output logic                       wb_ps_write,
  output logic                       wb_ps_data,
  output logic [$clog2(DEPTH+1)-1:0] pending_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  q_reg_write;
  logic [ADDR_W-1:0] q_reg_addr [DEPTH];
  logic [DATA_W-1:0] q_reg_data [DEPTH];
  logic [DEPTH-1:0]  q_ps_write;
  logic [DEPTH-1:0]  q_ps_data;

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  logic mem_win;
  logic fifo_empty;
  logic alu_useful;
  logic push;
  logic pop;
  logic bypass;

  always_comb begin
    alu_ready  = (pending_count < CNT_W'(DEPTH));
    mem_win    = mem_valid && (mem_reg_write || mem_ps_write);
    fifo_empty = (pending_count == '0);
    // Accepted entries that write nothing are dropped here, never queued or output.
    alu_useful = alu_valid && alu_ready && (alu_reg_write || alu_ps_write);
    pop        = !mem_win && !fifo_empty;
    bypass     = !mem_win && fifo_empty && alu_useful;
    push       = alu_useful && !bypass;
  end

  // FIFO storage; squash runs before the push so the same-cycle entry is never cleared.
  always_ff @(posedge clk) begin
    if (mem_win) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_reg_write && (q_reg_addr[i] == mem_reg_addr))
          q_reg_write[i] <= 1'b0;
        if (mem_ps_write)
          q_ps_write[i] <= 1'b0;
      end
    end
    if (push) begin
      q_reg_write[wr_ptr] <= alu_reg_write;
      q_reg_addr[wr_ptr]  <= alu_reg_addr;
      q_reg_data[wr_ptr]  <= alu_reg_data;
      q_ps_write[wr_ptr]  <= alu_ps_write;
      q_ps_data[wr_ptr]   <= alu_ps_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      pending_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   pending_count <= pending_count + CNT_W'(1);
        2'b01:   pending_count <= pending_count - CNT_W'(1);
        default: pending_count <= pending_count;
      endcase
    end
  end

  // Output stage: winner registered onto the write port, one cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_reg_write <= 1'b0;
      wb_reg_addr  <= '0;
      wb_reg_data  <= '0;
      wb_ps_write  <= 1'b0;
      wb_ps_data   <= 1'b0;
    end else if (mem_win) begin
      wb_reg_write <= mem_reg_write;
      wb_reg_addr  <= mem_reg_addr;
      wb_reg_data  <= mem_reg_data;
      wb_ps_write  <= mem_ps_write;
      wb_ps_data   <= mem_ps_data;
    end else if (pop) begin
      wb_reg_write <= q_reg_write[rd_ptr];
      wb_reg_addr  <= q_reg_addr[rd_ptr];
      wb_reg_data  <= q_reg_data[rd_ptr];
      wb_ps_write  <= q_ps_write[rd_ptr];
      wb_ps_data   <= q_ps_data[rd_ptr];
    end else if (bypass) begin
      wb_reg_write <= alu_reg_write;
      wb_reg_addr  <= alu_reg_addr;
      wb_reg_data  <= alu_reg_data;
      wb_ps_write  <= alu_ps_write;
      wb_ps_data   <= alu_ps_data;
    end else begin
      wb_reg_write <= 1'b0;
      wb_ps_write  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, alu_reg_write, alu_ps_write, alu_ps_data, alu_ready;
  logic [ADDR_W-1:0] alu_reg_addr;
  logic [DATA_W-1:0] alu_reg_data;
  logic              mem_valid, mem_reg_write, mem_ps_write, mem_ps_data;
  logic [ADDR_W-1:0] mem_reg_addr;
  logic [DATA_W-1:0] mem_reg_data;
  logic              wb_reg_write, wb_ps_write, wb_ps_data;
  logic [ADDR_W-1:0] wb_reg_addr;
  logic [DATA_W-1:0] wb_reg_data;
  logic [CNT_W-1:0]  pending_count;

  wb_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg_write(alu_reg_write), .alu_reg_addr(alu_reg_addr),
    .alu_reg_data(alu_reg_data), .alu_ps_write(alu_ps_write), .alu_ps_data(alu_ps_data),
    .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_reg_addr(mem_reg_addr),
    .mem_reg_data(mem_reg_data), .mem_ps_write(mem_ps_write), .mem_ps_data(mem_ps_data),
    .wb_reg_write(wb_reg_write), .wb_reg_addr(wb_reg_addr), .wb_reg_data(wb_reg_data),
    .wb_ps_write(wb_ps_write), .wb_ps_data(wb_ps_data), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              pw;
    logic              pd;
  } ent_t;

  ent_t q[$];
  ent_t e_out;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the pending ALU writes are a plain queue of records.
  task automatic model_step();
    ent_t a, m;
    bit   acc, mw;
    a = '{alu_reg_write, alu_reg_addr, alu_reg_data, alu_ps_write, alu_ps_data};
    m = '{mem_reg_write, mem_reg_addr, mem_reg_data, mem_ps_write, mem_ps_data};
    if (rst) begin
      q.delete();
      e_out = '{1'b0, '0, '0, 1'b0, 1'b0};
      return;
    end
    acc = alu_valid && (q.size() < DEPTH) && (alu_reg_write || alu_ps_write);
    mw  = mem_valid && (mem_reg_write || mem_ps_write);
    if (mw) begin
      e_out = m;
      foreach (q[i]) begin
        if (m.rw && q[i].addr == m.addr) q[i].rw = 1'b0;
        if (m.pw) q[i].pw = 1'b0;
      end
      if (acc) q.push_back(a);
    end else if (q.size() > 0) begin
      e_out = q.pop_front();
      if (acc) q.push_back(a);
    end else if (acc) begin
      e_out = a;
    end else begin
      e_out.rw = 1'b0;
      e_out.pw = 1'b0;
    end
  endtask

  task automatic cycle();
    #1;
    chk("alu_ready", alu_ready, (q.size() < DEPTH));
    model_step();
    @(posedge clk);
    #1;
    chk("wb_reg_write", wb_reg_write, e_out.rw);
    chk("wb_ps_write", wb_ps_write, e_out.pw);
    chk("wb_reg_addr", wb_reg_addr, e_out.addr);
    chk("wb_reg_data", wb_reg_data, e_out.data);
    chk("wb_ps_data", wb_ps_data, e_out.pd);
    chk("pending_count", pending_count, q.size());
  endtask

  task automatic set_alu(input logic v, input logic rw, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic pw, input logic pd);
    alu_valid = v; alu_reg_write = rw; alu_reg_addr = a; alu_reg_data = d;
    alu_ps_write = pw; alu_ps_data = pd;
  endtask

  task automatic set_mem(input logic v, input logic rw, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic pw, input logic pd);
    mem_valid = v; mem_reg_write = rw; mem_reg_addr = a; mem_reg_data = d;
    mem_ps_write = pw; mem_ps_data = pd;
  endtask

  task automatic idle();
    set_alu(0, 0, 0, 0, 0, 0);
    set_mem(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int k;
    e_out = '{1'b0, '0, '0, 1'b0, 1'b0};
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Bypass when idle
    set_alu(1, 1, 4'd3, 16'h1234, 0, 0);
    cycle();
    chk("bypass_addr", wb_reg_addr, 32'd3);
    chk("bypass_data", wb_reg_data, 32'h1234);
    chk("bypass_cnt", pending_count, 32'd0);
    idle();
    cycle();

    // Memory wins, ALU queued behind it
    set_mem(1, 1, 4'd5, 16'hBEEF, 0, 0);
    set_alu(1, 1, 4'd6, 16'h0001, 0, 0);
    cycle();
    chk("mem_first", wb_reg_data, 32'hBEEF);
    chk("mem_first_cnt", pending_count, 32'd1);
    idle();
    cycle();
    chk("alu_second", wb_reg_data, 32'h0001);
    idle();
    cycle();

    // Fill under continuous memory returns, then drain in order
    k = 1;
    for (int c = 0; c < 6; c++) begin
      set_mem(1, 1, 4'd15, 16'h5555, 0, 0);
      set_alu(k <= 6, 1, ADDR_W'(k), DATA_W'(16'h100 + k), 0, 0);
      #1;
      if (alu_ready && k <= 6) k++;
      cycle();
    end
    chk("fill_cnt", pending_count, 32'd4);
    chk("fill_ready", alu_ready, 32'd0);
    set_mem(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 12; c++) begin
      set_alu(k <= 6, 1, ADDR_W'(k), DATA_W'(16'h100 + k), 0, 0);
      #1;
      if (alu_ready && k <= 6) k++;
      cycle();
    end
    idle();
    cycle();

    // Full squash: same register and PS
    set_mem(1, 1, 4'd9, 16'h0999, 0, 0);
    set_alu(1, 1, 4'd2, 16'h0AAA, 1, 1);
    cycle();
    set_alu(0, 0, 0, 0, 0, 0);
    set_mem(1, 1, 4'd2, 16'h0BBB, 1, 0);
    cycle();
    chk("squash_mem_data", wb_reg_data, 32'h0BBB);
    idle();
    cycle();
    cycle();
    chk("squash_pop_rw", wb_reg_write, 32'd0);
    chk("squash_pop_pw", wb_ps_write, 32'd0);

    // Different register: no squash
    set_mem(1, 1, 4'd8, 16'h0888, 0, 0);
    set_alu(1, 1, 4'd4, 16'h0444, 0, 0);
    cycle();
    set_alu(0, 0, 0, 0, 0, 0);
    set_mem(1, 1, 4'd7, 16'h0777, 0, 0);
    cycle();
    idle();
    cycle();
    chk("nosquash_rw", wb_reg_write, 32'd1);
    chk("nosquash_addr", wb_reg_addr, 32'd4);

    // Reset with three pending entries
    for (int c = 0; c < 3; c++) begin
      set_mem(1, 1, 4'd14, 16'hE000, 0, 0);
      set_alu(1, 1, ADDR_W'(c), DATA_W'(16'hC000 + c), 0, 0);
      cycle();
    end
    chk("pre_rst_cnt", pending_count, 32'd3);
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_cnt", pending_count, 32'd0);
    chk("rst_ready", alu_ready, 32'd1);
    chk("rst_rw", wb_reg_write, 32'd0);
    for (int c = 0; c < 4; c++) cycle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_alu($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
              ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom),
              $urandom_range(0, 1), $urandom_range(0, 1));
      set_mem($urandom_range(0, 9) < 5, $urandom_range(0, 9) < 7,
              ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 1));
      cycle();
    end
    rst = 1'b0;
    idle();
    for (int c = 0; c < 6; c++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
